// File: rtl/wback_stage_pkg.sv
// rtl/wback_stage_pkg.sv - shared types and constants for the writeback stage
package wback_stage_pkg;

    localparam int RVGA_WORD_W = 32;

    typedef logic [RVGA_WORD_W-1:0] rvga_word;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rd_w_v;
        logic       ld_v;
        logic [2:0] ld_funct3;
    } rvga_cword;

    localparam logic [2:0] RVGA_LB  = 3'b000;
    localparam logic [2:0] RVGA_LH  = 3'b001;
    localparam logic [2:0] RVGA_LW  = 3'b010;
    localparam logic [2:0] RVGA_LBU = 3'b100;
    localparam logic [2:0] RVGA_LHU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } rvga_wb_state_e;

    // Captured instruction: control word, ALU result / load address, byte offset
    typedef struct packed {
        rvga_cword  cword;
        rvga_word   data;
        logic [1:0] offset;
    } rvga_wb_entry_s;

endpackage

// File: rtl/wback_stage_dff.sv
// rtl/wback_stage_dff.sv - enabled register with asynchronous active-low reset
module dff #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               w_v_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    // Load on write-enable, clear on reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o <= '0;
        end else if (w_v_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/wback_stage_load_extract.sv
// rtl/wback_stage_load_extract.sv - select and extend load data from an aligned word
module load_extract
    import wback_stage_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic [2:0]         funct3,
    input  logic [1:0]         offset,
    input  logic [width_p-1:0] word,
    output logic [width_p-1:0] result
);

    logic [width_p-1:0] byte_shift;
    logic [width_p-1:0] half_shift;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;

    // Halfword lane is chosen by offset[1] only; offset[0] is ignored
    always_comb begin
        byte_shift = word >> {offset, 3'b000};
        half_shift = word >> {offset[1], 4'b0000};
        byte_sel   = byte_shift[7:0];
        half_sel   = half_shift[15:0];
        case (funct3)
            RVGA_LB:  result = {{(width_p-8){byte_sel[7]}}, byte_sel};
            RVGA_LBU: result = {{(width_p-8){1'b0}}, byte_sel};
            RVGA_LH:  result = {{(width_p-16){half_sel[15]}}, half_sel};
            RVGA_LHU: result = {{(width_p-16){1'b0}}, half_sel};
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/wback_stage.sv
// rtl/wback_stage.sv - writeback stage with load wait, timeout flag; RVGA_WB_INSTRET_EN adds instret_o
module wback_stage
    import wback_stage_pkg::*;
#(
    parameter int width_p   = 32,
    parameter int timeout_p = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [$bits(rvga_cword)-1:0] cword_i,
    input  logic [width_p-1:0]           alu_data_i,
    input  logic                         mem_resp_v_i,
    input  logic [width_p-1:0]           mem_resp_data_i,
    output logic                         mem_resp_ready_o,
    output logic [4:0]                   rd_o,
    output logic [width_p-1:0]           rd_data_o,
    output logic                         rd_w_v_o,
    output logic                         stall_v_o,
    output logic                         err_o
`ifdef RVGA_WB_INSTRET_EN
    ,
    output logic [63:0]                  instret_o
`endif
);

    localparam logic [16:0] TMO_LIMIT = 17'(timeout_p);

    rvga_wb_state_e state_r, state_n;
    rvga_wb_entry_s entry_d, entry_q;
    logic [15:0]    tmo_cnt;
    logic [16:0]    tmo_inc;
    logic           err_r;
    logic           wait_v;
    logic           load_done;
    logic           retire;
    logic [width_p-1:0] ld_data;

    always_comb begin
        entry_d.cword  = rvga_cword'(cword_i);
        entry_d.data   = alu_data_i;
        entry_d.offset = alu_data_i[1:0];
    end

    dff #(.width_p($bits(rvga_wb_entry_s))) entry_reg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .w_v_i  (~stall_v_o),
        .data_i (entry_d),
        .data_o (entry_q)
    );

    load_extract #(.width_p(width_p)) extract (
        .funct3 (entry_q.cword.ld_funct3),
        .offset (entry_q.offset),
        .word   (mem_resp_data_i),
        .result (ld_data)
    );

    // State, timeout counter and sticky error flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            tmo_cnt <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            if (load_done) begin
                tmo_cnt <= '0;
            end else if (stall_v_o && (17'(tmo_cnt) != TMO_LIMIT)) begin
                tmo_cnt <= tmo_inc[15:0];
            end
            if (stall_v_o && (tmo_inc >= TMO_LIMIT)) begin
                err_r <= 1'b1;
            end
        end
    end

    // A load entry starts waiting in the same cycle it is captured, before the state register follows
    always_comb begin
        state_n          = state_r;
        wait_v           = (state_r == WAIT_LOAD) || (entry_q.cword.v && entry_q.cword.ld_v);
        load_done        = wait_v && mem_resp_v_i;
        mem_resp_ready_o = wait_v;
        stall_v_o        = wait_v && !mem_resp_v_i;
        retire           = load_done || (entry_q.cword.v && !entry_q.cword.ld_v);
        rd_w_v_o         = retire && entry_q.cword.rd_w_v && (entry_q.cword.rd != 5'd0);
        rd_o             = entry_q.cword.rd;
        rd_data_o        = entry_q.cword.ld_v ? ld_data : entry_q.data;
        tmo_inc          = {1'b0, tmo_cnt} + 17'd1;
        case (state_r)
            IDLE:      if (wait_v && !mem_resp_v_i) state_n = WAIT_LOAD;
            WAIT_LOAD: if (mem_resp_v_i)            state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    assign err_o = err_r;

`ifdef RVGA_WB_INSTRET_EN
    // Count every retired valid entry, whether or not it writes the regfile
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instret_o <= '0;
        end else if (retire) begin
            instret_o <= instret_o + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wback_stage.sv
// tb/tb_wback_stage.sv - scoreboard bench for wback_stage
module tb_wback_stage;
    import wback_stage_pkg::*;

    localparam int TMO = 4;

    logic                         clk;
    logic                         rst_i;
    logic [$bits(rvga_cword)-1:0] cword_i;
    logic [31:0]                  alu_data_i;
    logic                         mem_resp_v_i;
    logic [31:0]                  mem_resp_data_i;
    logic                         mem_resp_ready_o;
    logic [4:0]                   rd_o;
    logic [31:0]                  rd_data_o;
    logic                         rd_w_v_o;
    logic                         stall_v_o;
    logic                         err_o;
`ifdef RVGA_WB_INSTRET_EN
    logic [63:0]                  instret_o;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_ret    = 0;
    bit          err_exp  = 0;
    logic [36:0] sb[$];

    wback_stage #(.width_p(32), .timeout_p(TMO)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .cword_i          (cword_i),
        .alu_data_i       (alu_data_i),
        .mem_resp_v_i     (mem_resp_v_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .rd_o             (rd_o),
        .rd_data_o        (rd_data_o),
        .rd_w_v_o         (rd_w_v_o),
        .stall_v_o        (stall_v_o),
        .err_o            (err_o)
`ifdef RVGA_WB_INSTRET_EN
        ,
        .instret_o        (instret_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rvga_cword mk(input bit ld, input logic [2:0] f3, input logic [4:0] rd, input bit wv);
        rvga_cword c;
        c.v = 1'b1;
        c.rd = rd;
        c.rd_w_v = wv;
        c.ld_v = ld;
        c.ld_funct3 = f3;
        return c;
    endfunction

    function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> (8 * addr[1:0]);
        h = addr[1] ? (w >> 16) : w;
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b100:  return {24'h0, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b101:  return {16'h0, h[15:0]};
            default: return w;
        endcase
    endfunction

    // Every regfile write must match the oldest expected write
    always @(negedge clk) begin
        if (rst_i && rd_w_v_o) begin
            if (sb.size() == 0) begin
                check("write_unexpected", {63'd0, rd_w_v_o}, 64'd0);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                check("write_rd", {59'd0, rd_o}, {59'd0, e[36:32]});
                check("write_data", {32'd0, rd_data_o}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic send_alu(input logic [4:0] rd, input bit wv, input logic [31:0] d);
        cword_i = mk(1'b0, 3'b010, rd, wv);
        alu_data_i = d;
        if (wv && rd != 5'd0) sb.push_back({rd, d});
        n_ret++;
        tick();
        cword_i = '0;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input int delay);
        cword_i = mk(1'b1, f3, rd, 1'b1);
        alu_data_i = addr;
        if (rd != 5'd0) sb.push_back({rd, model_ld(f3, addr, data)});
        n_ret++;
        tick();
        cword_i = '0;
        alu_data_i = $urandom;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            check("load_stall", {63'd0, stall_v_o}, 64'd1);
            check("load_ready", {63'd0, mem_resp_ready_o}, 64'd1);
            check("load_err", {63'd0, err_o}, {63'd0, (err_exp || k >= TMO)});
            tick();
        end
        mem_resp_v_i = 1'b1;
        mem_resp_data_i = data;
        @(negedge clk);
        check("resp_stall", {63'd0, stall_v_o}, 64'd0);
        check("resp_err", {63'd0, err_o}, {63'd0, (err_exp || delay >= TMO)});
        tick();
        mem_resp_v_i = 1'b0;
        mem_resp_data_i = $urandom;
        if (delay >= TMO) err_exp = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b0;
        cword_i = '0;
        alu_data_i = '0;
        mem_resp_v_i = 1'b0;
        mem_resp_data_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_w_v", {63'd0, rd_w_v_o}, 64'd0);
        check("rst_stall", {63'd0, stall_v_o}, 64'd0);
        check("rst_ready", {63'd0, mem_resp_ready_o}, 64'd0);
        check("rst_rd", {59'd0, rd_o}, 64'd0);
        check("rst_rd_data", {32'd0, rd_data_o}, 64'd0);
        check("rst_err", {63'd0, err_o}, 64'd0);
        tick();
        rst_i = 1'b1;
        tick();

        send_alu(5'd5, 1'b1, 32'h0000_1234);
        @(negedge clk);
        check("add_stall", {63'd0, stall_v_o}, 64'd0);
        check("add_rd", {59'd0, rd_o}, 64'd5);
        tick();

        for (int i = 0; i < 4; i++) send_alu(5'(8 + i), 1'b1, $urandom);
        send_alu(5'd0, 1'b1, 32'hDEAD_BEEF);
        send_alu(5'd3, 1'b0, 32'hCAFE_F00D);
        cword_i = mk(1'b0, 3'b010, 5'd4, 1'b1);
        cword_i[$bits(rvga_cword)-1] = 1'b0;
        alu_data_i = 32'h1111_2222;
        tick();
        cword_i = '0;
        @(negedge clk);
        check("invalid_stall", {63'd0, stall_v_o}, 64'd0);
        tick();

        do_load(5'd7, RVGA_LB, 32'h0000_0101, 32'h1122_80FF, 3);
        do_load(5'd11, RVGA_LHU, 32'h0000_0102, 32'hBEEF_0000, 1);
        do_load(5'd12, RVGA_LH, 32'h0000_0102, 32'hBEEF_0000, 2);
        do_load(5'd13, RVGA_LW, 32'h0000_0102, 32'hBEEF_0000, 0);
        do_load(5'd14, RVGA_LBU, 32'h0000_0003, 32'h80A5_5A01, 1);
        do_load(5'd15, RVGA_LH, 32'h0000_0003, 32'h7FFF_1234, 2);
        do_load(5'd16, RVGA_LB, 32'h0000_0000, 32'h0000_007F, 0);
        do_load(5'd17, 3'b111, 32'h0000_0001, 32'h0123_4567, 1);
        do_load(5'd0, RVGA_LW, 32'h0000_0000, 32'hFFFF_FFFF, 2);
        send_alu(5'd18, 1'b1, 32'h0BAD_CAFE);

        mem_resp_v_i = 1'b1;
        mem_resp_data_i = 32'h5555_AAAA;
        @(negedge clk);
        check("stray_ready", {63'd0, mem_resp_ready_o}, 64'd0);
        tick();
        @(negedge clk);
        check("stray_stall", {63'd0, stall_v_o}, 64'd0);
        tick();
        mem_resp_v_i = 1'b0;

        do_load(5'd9, RVGA_LW, 32'h0000_0010, 32'h9876_5432, 6);
        send_alu(5'd19, 1'b1, 32'h0000_0042);
        @(negedge clk);
        check("err_sticky", {63'd0, err_o}, 64'd1);
        tick();
        tick();
`ifdef RVGA_WB_INSTRET_EN
        check("instret", instret_o, 64'(n_ret));
`endif

        cword_i = mk(1'b1, RVGA_LW, 5'd10, 1'b1);
        alu_data_i = 32'h0000_0020;
        tick();
        cword_i = '0;
        tick();
        @(negedge clk);
        check("pre_rst_stall", {63'd0, stall_v_o}, 64'd1);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check("mid_rst_rd_w_v", {63'd0, rd_w_v_o}, 64'd0);
        check("mid_rst_stall", {63'd0, stall_v_o}, 64'd0);
        check("mid_rst_ready", {63'd0, mem_resp_ready_o}, 64'd0);
        check("mid_rst_rd", {59'd0, rd_o}, 64'd0);
        check("mid_rst_rd_data", {32'd0, rd_data_o}, 64'd0);
        check("mid_rst_err", {63'd0, err_o}, 64'd0);
        tick();
        rst_i = 1'b1;
        mem_resp_v_i = 1'b1;
        mem_resp_data_i = 32'h1234_5678;
        @(negedge clk);
        check("post_rst_ready", {63'd0, mem_resp_ready_o}, 64'd0);
        check("post_rst_wr", {63'd0, rd_w_v_o}, 64'd0);
        check("post_rst_err", {63'd0, err_o}, 64'd0);
        tick();
        mem_resp_v_i = 1'b0;
        tick();
        tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
